// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA pixel FIFO.
// The optional underflow statistics counter is enabled by defining VGA_FIFO_STATS_EN.
package vga_pkg;

  typedef enum logic [1:0] {
    FLUSH  = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } vga_state_e;

  localparam int PIX_W               = 24;
  localparam int DEFAULT_DEPTH       = 1024;
  localparam int DEFAULT_PRIME_LEVEL = 640;
  localparam int UF_CNT_W            = 16;

endpackage

// File: rtl/vga_fifo_ram.sv
// Simple dual-port pixel store: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module vga_fifo_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = PIX_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; every word is
  // written before it can be read, and the top masks rd_data until then.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO between a pixel producer and a VGA controller: primes to a fill level, then streams.
// Defining VGA_FIFO_STATS_EN adds the saturating oUNDERFLOW_CNT output.
module vga_pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int PRIME_LEVEL = DEFAULT_PRIME_LEVEL,
  localparam int AW         = $clog2(DEPTH),
  localparam int PW         = AW + 1
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iFRAME_START,
  input  logic          iPIX_VALID,
  input  logic [7:0]    iPIX_R,
  input  logic [7:0]    iPIX_G,
  input  logic [7:0]    iPIX_B,
  output logic          oPIX_READY,
  input  logic          iREAD_Request,
  output logic [7:0]    oRed,
  output logic [7:0]    oGreen,
  output logic [7:0]    oBlue,
  output logic [PW-1:0] oLEVEL,
  output logic          oUNDERFLOW
`ifdef VGA_FIFO_STATS_EN
  ,
  output logic [UF_CNT_W-1:0] oUNDERFLOW_CNT
`endif
);

  typedef logic [PW-1:0] ptr_t;
  localparam ptr_t PRIME_LVL = PW'(PRIME_LEVEL);

  vga_state_e       state_q, state_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  ptr_t             level_q, level_d;
  logic             underflow_q, underflow_d;
  logic             show_q, show_d;
  logic [PIX_W-1:0] rd_data;
`ifdef VGA_FIFO_STATS_EN
  logic [UF_CNT_W-1:0] uf_cnt_q, uf_cnt_d;
`endif

  logic full, empty, pop_req, pop_ok, pop_uf, wr_en;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign pop_req = (state_q == STREAM) && iREAD_Request && !iFRAME_START;
  assign pop_ok  = pop_req && !empty;
  assign pop_uf  = pop_req && empty;

  assign oPIX_READY = !full && (state_q != FLUSH);
  // A full FIFO still takes a write when the same cycle pops a word out of it.
  assign wr_en = iPIX_VALID && !iFRAME_START && (oPIX_READY || (full && pop_ok));

  always_comb begin
    // NOTE: every _d starts from its _q so no path leaves a variable unassigned (no latch).
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    underflow_d = underflow_q;
    show_d      = show_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      show_d   = 1'b1;
    end
    if (pop_uf) begin
      underflow_d = 1'b1;
      show_d      = 1'b0;
    end

    if (iFRAME_START) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        FLUSH: begin
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          underflow_d = 1'b0;
          state_d     = PRIME;
        end
        PRIME:   if (level_q >= PRIME_LVL) state_d = STREAM;
        STREAM:  state_d = STREAM;
        default: state_d = FLUSH;
      endcase
    end

    // Colour outputs are only ever non-zero while streaming.
    if (iFRAME_START || state_q != STREAM) show_d = 1'b0;

    level_d = wr_ptr_d - rd_ptr_d;
  end

`ifdef VGA_FIFO_STATS_EN
  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (pop_uf && uf_cnt_q != '1) uf_cnt_d = uf_cnt_q + UF_CNT_W'(1);
  end
`endif

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= FLUSH;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      show_q      <= 1'b0;
`ifdef VGA_FIFO_STATS_EN
      uf_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
      show_q      <= show_d;
`ifdef VGA_FIFO_STATS_EN
      uf_cnt_q    <= uf_cnt_d;
`endif
    end
  end

  vga_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (PIX_W)
  ) u_ram (
    .clk     (iCLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data ({iPIX_R, iPIX_G, iPIX_B}),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (rd_data)
  );

  // show_q is reset asynchronously, so the colours drop to zero with iRST_N.
  assign {oRed, oGreen, oBlue} = show_q ? rd_data : '0;
  assign oLEVEL     = level_q;
  assign oUNDERFLOW = underflow_q;
`ifdef VGA_FIFO_STATS_EN
  assign oUNDERFLOW_CNT = uf_cnt_q;
`endif

endmodule

// File: doc/vga_pixel_fifo.md
VGA_PIXEL_FIFO -- requirements
Module: vga_pixel_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 1024, meaning FIFO entries (power of two, at least 2).
REQ-002 SHALL provide parameter PRIME_LEVEL, default 640, meaning occupancy required before streaming starts (1..DEPTH).
REQ-003 SHALL provide the following ports; one clock, reset asynchronous active-low:
iCLK  in  1  pixel clock, rising edge.
iRST_N  in  1  asynchronous active-low reset.
iFRAME_START  in  1  one-cycle pulse at vertical blank start.
iPIX_VALID  in  1  upstream pixel valid.
iPIX_R / iPIX_G / iPIX_B  in  8 each  upstream pixel.
oPIX_READY  out  1  FIFO accepts a pixel this cycle.
iREAD_Request  in  1  downstream pixel pop request (active-region strobe).
oRed / oGreen / oBlue  out  8 each  pixel to the VGA controller colour inputs.
oLEVEL  out  log2(DEPTH)+1  current occupancy.
oUNDERFLOW  out  1  sticky; a pop occurred while the FIFO was empty.

Function
REQ-004 SHALL store {R,G,B} as a 24-bit word in a circular buffer with wrapping write/read pointers, each log2(DEPTH)+1 bits wide; full = MSBs differ and remaining bits are equal; empty = pointers are equal.
REQ-005 SHALL write when iPIX_VALID && oPIX_READY; oPIX_READY = !full && state != FLUSH.
REQ-006 SHALL implement a three-state FSM: FLUSH -> PRIME -> STREAM.
REQ-007 FLUSH: SHALL reset both pointers to 0 and clear oUNDERFLOW, lasting exactly one cycle, then go to PRIME.
REQ-008 PRIME: SHALL accept writes and ignore iREAD_Request; SHALL go to STREAM in the cycle after oLEVEL >= PRIME_LEVEL.
REQ-009 STREAM: each iREAD_Request cycle SHALL pop one word; oRed/oGreen/oBlue SHALL update on the next rising edge (latency 1) and hold otherwise.
REQ-010 A pop while empty in STREAM SHALL leave the pointers unchanged, drive 0/0/0 on the next cycle and set oUNDERFLOW.
REQ-011 iFRAME_START in any state SHALL force FLUSH on the next edge; this takes priority over a simultaneous write or pop in that cycle, which is dropped.
REQ-012 A simultaneous write and pop in STREAM when full SHALL perform both; oLEVEL is unchanged.
REQ-013 A simultaneous write and pop in STREAM when empty SHALL count as underflow (no bypass); the write is stored.
REQ-014 oLEVEL SHALL equal wr_ptr - rd_ptr modulo 2^(log2(DEPTH)+1) and be registered consistently with the pointers.
REQ-015 Outputs outside STREAM SHALL hold 0/0/0.

Reset
REQ-016 iRST_N low SHALL asynchronously force the FSM to FLUSH, pointers to 0, oRed/oGreen/oBlue to 0, oUNDERFLOW to 0 and oLEVEL to 0.
REQ-017 Deassertion SHALL be synchronised externally; the first active edge performs the FLUSH cycle.
REQ-018 Reset mid-frame SHALL discard all stored pixels.

Configuration
REQ-019 With VGA_FIFO_STATS_EN defined, the block SHALL add output oUNDERFLOW_CNT (16 bits). The counter increments on each underflow pop, saturates at 16'hFFFF and clears on reset only, not on FLUSH.
REQ-020 Without VGA_FIFO_STATS_EN, the port and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-021 A shared package vga_pkg SHALL hold the FSM state enum (FLUSH, PRIME, STREAM), the pixel word width constant (24) and the default DEPTH and PRIME_LEVEL.
REQ-022 The storage SHALL be one sub-module, vga_fifo_ram: simple dual-port, synchronous read, one write and one read port on iCLK, with no reset on the array.

Verification
REQ-023 Reset, then iFRAME_START, then write 640 pixels of value i -> oPIX_READY=1 throughout; STREAM is entered the cycle after oLEVEL=640.
REQ-024 In STREAM, assert iREAD_Request for 640 cycles -> outputs are pixels 0..639 in order, each one cycle after its request; oLEVEL returns to 0 and oUNDERFLOW=0.
REQ-025 Fill to 1024 -> oPIX_READY=0 and an extra write is dropped; a write and pop together keep oLEVEL=1024.
REQ-026 Empty FIFO in STREAM plus 3 pops -> outputs 0/0/0 and oUNDERFLOW=1; with VGA_FIFO_STATS_EN, oUNDERFLOW_CNT=3.
REQ-027 iFRAME_START with 300 entries stored -> next cycle in FLUSH with oPIX_READY=0, then oLEVEL=0 and state PRIME.
REQ-028 iRST_N pulsed low mid-stream with 500 entries -> outputs 0 immediately (asynchronous) and oLEVEL=0.
